// File: rtl/mac_vector_engine_pkg.sv
// mac_pkg: shared state type, default widths and requantisation for mac_vector_engine.
// Build macro MAC_SATURATE_EN: when defined requant clamps to the OUT_W range, otherwise it wraps.
package mac_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_e;
  localparam int DEF_DATA_W = 18;
  localparam int DEF_LANES = 2;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_LEN_W = 10;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_OUT_W = 18;
  localparam int PROD_W = 2 * DEF_DATA_W;
  localparam int SUM_W = PROD_W + $clog2(DEF_LANES);
  // v is the already-shifted accumulator sign-extended to 64 bits; the caller keeps the low w bits
  function automatic logic signed [63:0] requant(input logic signed [63:0] v, input int w);
`ifdef MAC_SATURATE_EN
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction
endpackage

// File: rtl/mac_vector_engine_if.sv
// mac_vector_engine_if: job control, operand stream and result stream of the MAC engine.
// master drives start/clear/vec_len/bias/in_*/out_ready; slave drives busy/in_ready/out_*/acc_overflow.
interface mac_vector_engine_if #(
  parameter int DATA_W = 18,
  parameter int LANES = 2,
  parameter int ACC_W = 48,
  parameter int LEN_W = 10,
  parameter int OUT_W = 18
);
  logic start, clear, busy;
  logic [LEN_W-1:0] vec_len;
  logic signed [ACC_W-1:0] bias;
  logic in_valid, in_ready;
  logic [LANES*DATA_W-1:0] in_a, in_b;
  logic out_valid, out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic signed [ACC_W-1:0] out_acc;
  logic acc_overflow;
  modport master (
    output start, clear, vec_len, bias, in_valid, in_a, in_b, out_ready,
    input busy, in_ready, out_valid, out_data, out_acc, acc_overflow
  );
  modport slave (
    input start, clear, vec_len, bias, in_valid, in_a, in_b, out_ready,
    output busy, in_ready, out_valid, out_data, out_acc, acc_overflow
  );
endinterface

// File: rtl/mac_vector_engine_lane_sum.sv
// mac_lane_sum: combinational sum of LANES signed PW-bit products into SW bits.
// Ports: prod_i packed products (lane i at [i*PW +: PW]), sum_o signed sum.
module mac_lane_sum #(
  parameter int PW = 36,
  parameter int LANES = 2,
  parameter int SW = 37
) (
  input  logic [LANES*PW-1:0] prod_i,
  output logic signed [SW-1:0] sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) sum_o = sum_o + SW'(signed'(prod_i[i*PW +: PW]));
  end
endmodule

// File: rtl/mac_vector_engine.sv
// mac_vector_engine: multi-lane signed MAC over vec_len beats on top of a bias, requantised result.
// Ports: clk, reset_n (async active-low), bus (mac_vector_engine_if.slave: job control, operand and result streams).
// Build macro MAC_SATURATE_EN selects saturating requantisation; default wraps.
module mac_vector_engine
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int OUT_W = DEF_OUT_W
) (
  input logic clk,
  input logic reset_n,
  mac_vector_engine_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + $clog2(LANES);
  if (ACC_W < SW + 1 || ACC_W > 64) begin : g_bad_acc_w
    $error("mac_vector_engine: ACC_W too small for DATA_W/LANES or above 64");
  end
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, step, acc_nx;
  logic [LANES*PW-1:0] prod_q, prod_d;
  logic pv_q, pv_d, ovf_q, ovf_d, fire, step_ovf;
  logic signed [SW-1:0] sum;
  logic signed [63:0] shifted;
  mac_lane_sum #(.PW(PW), .LANES(LANES), .SW(SW)) u_sum (.prod_i(prod_q), .sum_o(sum));
  assign fire = state_q == S_ACCUM && bus.in_valid;
  assign step = ACC_W'(sum);
  assign acc_nx = acc_q + step;
  // signed overflow: addends share a sign that the wrapped result does not
  assign step_ovf = pv_q && acc_q[ACC_W-1] == step[ACC_W-1] && acc_nx[ACC_W-1] != acc_q[ACC_W-1];
  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i*PW +: PW] = PW'(signed'(bus.in_a[i*DATA_W +: DATA_W])) * PW'(signed'(bus.in_b[i*DATA_W +: DATA_W]));
  end
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    acc_d = pv_q ? acc_nx : acc_q;
    ovf_d = ovf_q | step_ovf;
    pv_d = fire;
    if (bus.clear) begin
      state_d = S_IDLE;
      len_d = '0;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
      pv_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          len_d = bus.vec_len;
          cnt_d = '0;
          acc_d = bus.bias;
          ovf_d = 1'b0;
          state_d = bus.vec_len == '0 ? S_DONE : S_ACCUM;
        end
        S_ACCUM: begin
          cnt_d = cnt_q + LEN_W'(fire);
          state_d = fire && cnt_q + LEN_W'(1) == len_q ? S_DRAIN : S_ACCUM;
        end
        S_DRAIN: state_d = S_DONE;
        default: state_d = bus.out_ready ? S_IDLE : S_DONE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      prod_q <= '0;
      pv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      prod_q <= prod_d;
      pv_q <= pv_d;
      ovf_q <= ovf_d;
    end
  end
  assign shifted = 64'(acc_q >>> FRAC_BITS);
  assign bus.busy = state_q != S_IDLE;
  assign bus.in_ready = state_q == S_ACCUM;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.out_acc = bus.out_valid ? acc_q : '0;
  assign bus.out_data = bus.out_valid ? OUT_W'(requant(shifted, OUT_W)) : '0;
  assign bus.acc_overflow = ovf_q;
endmodule

// File: tb/tb_mac_vector_engine.sv
// tb_mac_vector_engine: table vectors, hand sequences and random jobs against an arithmetic model.
module tb_mac_vector_engine;
  typedef struct {
    int len; longint bias; int a0, a1, b0, b1, gap, stall;
    longint e_acc, e_data; bit e_ovf;
  } vec_t;
  localparam longint MAXA = 64'sd140737488355327;
  localparam longint MINA = -64'sd140737488355328;
`ifdef MAC_SATURATE_EN
  localparam longint D_SATP = 131071, D_SATN = -131072, D_OVF = -131072;
`else
  localparam longint D_SATP = -8192, D_SATN = 8191, D_OVF = 0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  int n_checks = 0, n_errors = 0;
  logic signed [17:0] ba[8][2], bb[8][2];
  vec_t tbl[7];
  always #5 clk = ~clk;
  mac_vector_engine_if bus ();
  mac_vector_engine dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint requant_m(input longint acc);
    longint sh, m;
    sh = acc >>> 8;
`ifdef MAC_SATURATE_EN
    return sh > 131071 ? 131071 : sh < -131072 ? -131072 : sh;
`else
    m = sh & 262143;
    return m >= 131072 ? m - 262144 : m;
`endif
  endfunction

  task automatic model(input int len, input longint bias, output longint acc, output bit ovf);
    longint ex;
    logic signed [47:0] w;
    acc = bias;
    ovf = 0;
    for (int k = 0; k < len; k++) begin
      ex = acc + longint'(ba[k][0]) * longint'(bb[k][0]) + longint'(ba[k][1]) * longint'(bb[k][1]);
      if (ex > MAXA || ex < MINA) ovf = 1;
      w = ex[47:0];
      acc = w;
    end
  endtask

  task automatic run_job(input string tag, input int len, input longint bias, input int gap, input int stall,
                         input longint e_acc, input longint e_data, input bit e_ovf);
    logic signed [47:0] h_acc;
    logic signed [17:0] h_data;
    @(negedge clk);
    bus.start = 1; bus.vec_len = 10'(len); bus.bias = 48'(bias);
    @(negedge clk);
    bus.start = 0;
    chk({tag, ".ovf_clr"}, bus.acc_overflow, 0);
    if (len == 0) begin
      chk({tag, ".valid_at_start+1"}, bus.out_valid, 1);
      chk({tag, ".in_ready_empty"}, bus.in_ready, 0);
    end else begin
      for (int k = 0; k < len; k++) begin
        repeat (gap) begin
          bus.in_valid = 0; bus.in_a = 36'({$urandom, $urandom}); bus.in_b = 36'({$urandom, $urandom});
          @(negedge clk);
        end
        bus.in_valid = 1; bus.in_a = {ba[k][1], ba[k][0]}; bus.in_b = {bb[k][1], bb[k][0]};
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        @(negedge clk);
      end
      bus.in_valid = 0;
      chk({tag, ".drain_no_valid"}, bus.out_valid, 0);
      chk({tag, ".drain_in_ready"}, bus.in_ready, 0);
      @(negedge clk);
      chk({tag, ".valid_at_t+2"}, bus.out_valid, 1);
    end
    h_acc = bus.out_acc; h_data = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 0; bus.start = (s == 1);
      @(negedge clk);
      chk({tag, ".stall_valid"}, bus.out_valid, 1);
      chk({tag, ".stall_acc"}, bus.out_acc, h_acc);
      chk({tag, ".stall_data"}, bus.out_data, h_data);
    end
    chk({tag, ".out_acc"}, bus.out_acc, e_acc);
    chk({tag, ".out_data"}, bus.out_data, e_data);
    chk({tag, ".acc_overflow"}, bus.acc_overflow, e_ovf);
    bus.out_ready = 1; bus.start = 1;
    @(negedge clk);
    bus.out_ready = 0; bus.start = 0;
    chk({tag, ".idle_busy"}, bus.busy, 0);
    chk({tag, ".idle_valid"}, bus.out_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".in_ready"}, bus.in_ready, 0);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".out_acc"}, bus.out_acc, 0);
    chk({tag, ".out_data"}, bus.out_data, 0);
    chk({tag, ".acc_overflow"}, bus.acc_overflow, 0);
  endtask

  initial begin
    longint m_acc;
    bit m_ovf;
    int len;
    longint bias;
    bus.start = 0; bus.clear = 0; bus.vec_len = '0; bus.bias = '0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 0;
    tbl[0] = '{3, 0, 512, 256, 256, 256, 0, 0, 589824, 2304, 0};
    tbl[1] = '{0, 1000, 0, 0, 0, 0, 0, 0, 1000, 3, 0};
    tbl[2] = '{4, 0, 131071, 131071, 131071, 131071, 0, 1, 64'sd137436856328, D_SATP, 0};
    tbl[3] = '{4, 0, 131071, 131071, -131071, -131071, 0, 0, -64'sd137436856328, D_SATN, 0};
    tbl[4] = '{4, 0, -300, 1000, 77, -3, 2, 5, -104400, -408, 0};
    tbl[5] = '{1, MAXA, 1, 0, 1, 0, 0, 0, MINA, D_OVF, 1};
    tbl[6] = '{2, -1000, 10, -20, 30, 40, 1, 2, -2000, -8, 0};
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 8; k++) begin
        ba[k][0] = 18'(tbl[i].a0); ba[k][1] = 18'(tbl[i].a1);
        bb[k][0] = 18'(tbl[i].b0); bb[k][1] = 18'(tbl[i].b1);
      end
      run_job($sformatf("vec%0d", i), tbl[i].len, tbl[i].bias, tbl[i].gap, tbl[i].stall,
              tbl[i].e_acc, tbl[i].e_data, tbl[i].e_ovf);
    end
    // abort after two of five beats, then a short job
    @(negedge clk);
    bus.start = 1; bus.vec_len = 10'd5; bus.bias = 48'd123;
    @(negedge clk);
    bus.start = 0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1; bus.in_a = {18'sd5, 18'sd6}; bus.in_b = {18'sd7, 18'sd8};
      @(negedge clk);
    end
    bus.in_valid = 0; bus.clear = 1;
    @(negedge clk);
    bus.clear = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1;
      check_zero($sformatf("abort%0d", c));
      @(negedge clk);
    end
    bus.in_valid = 0;
    ba[0][0] = -18'sd1; ba[0][1] = 0; bb[0][0] = 18'sd7; bb[0][1] = 0;
    run_job("after_abort", 1, -5, 0, 0, -12, -1, 0);
    // asynchronous reset while draining
    ba[0][0] = 18'sd3; bb[0][0] = 18'sd4;
    @(negedge clk);
    bus.start = 1; bus.vec_len = 10'd1; bus.bias = 48'd99;
    @(negedge clk);
    bus.start = 0; bus.in_valid = 1; bus.in_a = {18'sd0, 18'sd3}; bus.in_b = {18'sd0, 18'sd4};
    @(negedge clk);
    bus.in_valid = 0;
    chk("drain.busy", bus.busy, 1);
    #1 reset_n = 0;
    #1 check_zero("async_rst");
    @(negedge clk);
    chk("async_rst.held_idle", bus.out_valid, 0);
    reset_n = 1;
    for (int r = 0; r < 25; r++) begin
      len = (r % 8 == 7) ? 0 : int'($urandom_range(1, 6));
      bias = longint'($signed({$urandom, $urandom})) >>> 24;
      for (int k = 0; k < 8; k++) begin
        ba[k][0] = 18'($urandom); ba[k][1] = 18'($urandom);
        bb[k][0] = 18'($urandom); bb[k][1] = 18'($urandom);
      end
      model(len, bias, m_acc, m_ovf);
      run_job($sformatf("rnd%0d", r), len, bias, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              m_acc, requant_m(m_acc), m_ovf);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
